// File: rtl/iopage_pkg.sv
// Shared definitions for the I/O-page initiator: FSM encoding, page match,
// interrupt vector width, access counter width and write-lane steering.
// Optional build macro used by the top level: IOPAGE_WAIT_EN.
package iopage_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [2:0] IOPAGE_HI = 3'b111;
    localparam int         VEC_W     = 8;
    localparam int         CNT_W     = 5;

    // A byte written at an odd address travels on the high lane, so the low
    // byte is mirrored onto both halves of the device data bus.
    function automatic logic [15:0] lane_wdata(input logic byte_op, input logic odd,
                                               input logic [15:0] wdata);
        return (byte_op && odd) ? {wdata[7:0], wdata[7:0]} : wdata;
    endfunction

endpackage

// File: rtl/iopage_master_if.sv
// CPU-side request/response bus of the I/O-page initiator.
interface iopage_master_if;
    logic        bus_req;
    logic        bus_wr;
    logic        bus_byte;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic        bus_nxm;

    modport master (output bus_req, bus_wr, bus_byte, bus_addr, bus_wdata,
                    input  bus_rdata, bus_ack, bus_nxm);
    modport slave  (input  bus_req, bus_wr, bus_byte, bus_addr, bus_wdata,
                    output bus_rdata, bus_ack, bus_nxm);
endinterface

// File: rtl/iopage_master_int_arb.sv
// Fixed-priority interrupt arbiter: lowest index wins, vector and one-hot
// acknowledge are registered on the CPU acknowledge pulse.
module int_arb
    import iopage_pkg::*;
#(
    parameter int NDEV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NDEV-1:0]       int_req,
    input  logic [VEC_W*NDEV-1:0] int_vec,
    input  logic                  int_ack,
    output logic                  int_pending,
    output logic [VEC_W-1:0]      int_vector,
    output logic [NDEV-1:0]       int_ack_dev
);

    logic [NDEV-1:0]  win;
    logic [VEC_W-1:0] win_vec;

    assign int_pending = |int_req;

    // Priority encode: scan from the top so the lowest asserted index is left standing.
    always_comb begin
        win     = '0;
        win_vec = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (int_req[i]) begin
                win     = '0;
                win[i]  = 1'b1;
                win_vec = int_vec[i*VEC_W +: VEC_W];
            end
        end
    end

    // Capture the winner on acknowledge; the device pulse lasts exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_vector  <= '0;
            int_ack_dev <= '0;
        end else begin
            int_ack_dev <= int_ack ? win : '0;
            if (int_ack) int_vector <= win_vec;
        end
    end

endmodule

// File: rtl/iopage_master.sv
// CPU-side initiator for the I/O-page register bus: sequences single reads and
// writes to the device responders, reports NXM, and hosts the interrupt arbiter.
// Build macro IOPAGE_WAIT_EN: lets devices stretch ACCESS via iopage_wait, with
// a TIMEOUT-cycle limit that ends the access as NXM.
module iopage_master
    import iopage_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int NDEV        = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    iopage_master_if.slave        bus,
    output logic [12:0]           iopage_addr,
    output logic                  iopage_rd,
    output logic                  iopage_wr,
    output logic                  iopage_byte_op,
    output logic [15:0]           iopage_wdata,
    input  logic [15:0]           iopage_rdata,
    input  logic                  iopage_decode,
    input  logic                  iopage_wait,
    input  logic [NDEV-1:0]       int_req,
    input  logic [VEC_W*NDEV-1:0] int_vec,
    output logic                  int_pending,
    input  logic                  int_ack,
    output logic [VEC_W-1:0]      int_vector,
    output logic [NDEV-1:0]       int_ack_dev
);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(WAIT_STATES);

    logic [1:0]       state;
    logic             wr_q;
    logic             nxm_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] acc_last;
    logic             acc_done;
    logic             acc_tmo;
    logic [15:0]      rdata_q;

    // Writes strobe for a single cycle; reads hold for WAIT_STATES+1 cycles.
    assign acc_last = wr_q ? '0 : RD_LAST;

`ifdef IOPAGE_WAIT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    // Finish once the minimum length is met and the device stops stretching.
    always_comb begin
        acc_done = (cnt >= acc_last) && !iopage_wait;
        acc_tmo  = !acc_done && (cnt == TO_LAST);
    end
`else
    logic unused_wait;
    assign unused_wait = iopage_wait | (TIMEOUT == 0);

    // Fixed access length; device stretch requests are not honoured.
    always_comb begin
        acc_done = (cnt == acc_last);
        acc_tmo  = 1'b0;
    end
`endif

    // Access sequencer. Out-of-page requests still spend one cycle in SETUP and
    // a decode miss occupies the ACCESS slot with strobes suppressed, so NXM is
    // acknowledged 2 and 3 cycles after the request respectively.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            wr_q           <= 1'b0;
            nxm_q          <= 1'b0;
            cnt            <= '0;
            rdata_q        <= '0;
            iopage_addr    <= '0;
            iopage_byte_op <= 1'b0;
            iopage_wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.bus_req) begin
                        iopage_addr    <= bus.bus_addr[12:0];
                        iopage_byte_op <= bus.bus_byte;
                        iopage_wdata   <= lane_wdata(bus.bus_byte, bus.bus_addr[0], bus.bus_wdata);
                        wr_q           <= bus.bus_wr;
                        nxm_q          <= (bus.bus_addr[15:13] != IOPAGE_HI);
                        state          <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt <= '0;
                    if (nxm_q) begin
                        state <= S_RESP;
                    end else begin
                        nxm_q <= !iopage_decode;
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (nxm_q || acc_done) begin
                        if (!nxm_q && !wr_q) rdata_q <= iopage_rdata;
                        state <= S_RESP;
                    end else if (acc_tmo) begin
                        nxm_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign iopage_rd     = (state == S_ACCESS) && !wr_q && !nxm_q;
    assign iopage_wr     = (state == S_ACCESS) &&  wr_q && !nxm_q;
    assign bus.bus_ack   = (state == S_RESP);
    assign bus.bus_nxm   = (state == S_RESP) && nxm_q;
    assign bus.bus_rdata = rdata_q;

    int_arb #(.NDEV(NDEV)) u_int_arb (
        .clk         (clk),
        .reset       (reset),
        .int_req     (int_req),
        .int_vec     (int_vec),
        .int_ack     (int_ack),
        .int_pending (int_pending),
        .int_vector  (int_vector),
        .int_ack_dev (int_ack_dev)
    );

endmodule

// File: doc/iopage_master.md
Name: iopage_master

Overview:
- CPU-side initiator for the I/O-page register bus; the counterpart of the device-side register responders (clock CSR, console, disk CSRs).
- Turns single CPU requests into iopage_rd/iopage_wr cycles, returns read data, and flags non-existent-memory (NXM) when no device decodes.
- Also arbitrates device interrupt requests and delivers the winning vector to the CPU on an acknowledge handshake.

Parameters:
- WAIT_STATES, 1, extra ACCESS cycles before read data is sampled (range 0..7).
- NDEV, 4, number of interrupt sources; index 0 has highest priority.
- TIMEOUT, 16, maximum ACCESS cycles when IOPAGE_WAIT_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus_req  in  1  CPU access request; held until bus_ack
- bus_wr  in  1  1 = write, 0 = read; valid with bus_req
- bus_byte  in  1  byte operation
- bus_addr  in  16  CPU address; I/O page when bus_addr[15:13] == 3'b111
- bus_wdata  in  16  write data
- bus_rdata  out  16  read data; valid with bus_ack
- bus_ack  out  1  one-cycle completion pulse
- bus_nxm  out  1  one-cycle NXM pulse; coincides with bus_ack
- iopage_addr  out  13  registered bus_addr[12:0]
- iopage_rd  out  1  read strobe to devices
- iopage_wr  out  1  write strobe to devices
- iopage_byte_op  out  1  registered bus_byte
- iopage_wdata  out  16  data to devices
- iopage_rdata  in  16  muxed device data_out
- iopage_decode  in  1  OR of all device decode outputs
- iopage_wait  in  1  device stretch request; used only with IOPAGE_WAIT_EN
- int_req  in  NDEV  level interrupt requests
- int_vec  in  8*NDEV  vectors; device i occupies bits [8i+7:8i]
- int_pending  out  1  any int_req asserted
- int_ack  in  1  CPU acknowledge, one-cycle pulse
- int_vector  out  8  vector latched at int_ack
- int_ack_dev  out  NDEV  one-hot, one-cycle pulse to the granted device

Behaviour:
- Reset: all outputs 0; state IDLE. Reset during an access drops iopage_rd/iopage_wr immediately and issues no bus_ack.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On bus_req, latch addr, wr, byte and wdata, then go to SETUP.
  - If bus_addr[15:13] != 3'b111, go directly to RESP with NXM; no strobe is issued.
- SETUP (1 cycle): iopage_addr is stable.
  - iopage_decode = 0 -> RESP with NXM.
  - Otherwise -> ACCESS.
- ACCESS, read: iopage_rd is high for WAIT_STATES+1 cycles; iopage_rdata is registered on the last cycle.
- ACCESS, write: iopage_wr is high for exactly 1 cycle; wait states do not apply.
- RESP: bus_ack = 1 for one cycle (bus_nxm too on NXM), then IDLE.
  - The CPU must drop bus_req in the cycle after bus_ack.
  - bus_req still high in IDLE is treated as a new request.
- Latency from bus_req to bus_ack:
  - read: WAIT_STATES+3 cycles
  - write: 3 cycles
  - NXM: 2 cycles (out-of-page) or 3 cycles (no decode)
- Byte write at an odd address: iopage_wdata = {wdata[7:0], wdata[7:0]}; otherwise iopage_wdata = wdata.
- Byte read: the full word is returned; the CPU selects the lane.
- Interrupts:
  - int_pending is combinational.
  - On int_ack, the lowest-index asserted int_req wins. int_vector is registered from its field, and int_ack_dev pulses its bit the next cycle.
  - int_ack with no request: int_vector = 0, no int_ack_dev pulse.
  - Interrupt handling is independent of, and concurrent with, bus accesses.

Optional Feature:
- IOPAGE_WAIT_EN defined:
  - ACCESS is extended while iopage_wait = 1, after the minimum WAIT_STATES+1 cycles.
  - If the total ACCESS length reaches TIMEOUT cycles, strobes drop and RESP signals NXM.
- Not defined: iopage_wait is ignored; the fixed timing above applies.

Decomposition:
- Package iopage_pkg:
  - state encoding
  - IOPAGE_HI = 3'b111
  - vector width 8
  - TIMEOUT counter width
- Sub-module int_arb: fixed-priority encoder, vector mux, acknowledge registers.

Test Plan:
- Word write 16'o177546 data 16'o000100:
  - iopage_addr = 13'o17546, iopage_wr high exactly 1 cycle, iopage_wdata = 16'o000100
  - bus_ack 3 cycles after bus_req, bus_nxm = 0
- Read, WAIT_STATES = 2, device returns 16'o000200:
  - iopage_rd high for 3 cycles
  - bus_rdata = 16'o000200 with bus_ack at cycle 5
- Address 16'o177000 with iopage_decode = 0: bus_ack and bus_nxm at cycle 3, no strobe. Address 16'o001000: NXM at cycle 2.
- Byte write 16'o177547 with wdata 16'o000123: iopage_wdata = 16'h5353, iopage_byte_op = 1.
- int_req = 4'b0110, vectors 0o100 (device 1) and 0o060 (device 2), pulse int_ack:
  - int_vector = 8'o100, int_ack_dev = 4'b0010
  - drop device 1's request and repeat: 8'o060, 4'b0100
- Assert reset during a read's ACCESS: iopage_rd = 0 immediately, no bus_ack; the next request completes normally. With IOPAGE_WAIT_EN and iopage_wait held high, NXM after TIMEOUT.
